// File: rtl/up_down_counter.sv
// ---------------------------------------------------------------------------
// up_down_counter
//
// Purpose:
//   N-bit synchronous up/down counter with an active-low parallel load, an
//   active-low count enable and an active-low ripple-carry output.
//   Each rising edge applies the first matching action in this order:
//   reset, load, count, hold.
//
// Parameters:
//   N        - counter width in bits (2..32, default 4)
//
// Ports:
//   clk      - single clock; every state update happens on its rising edge
//   reset    - synchronous active-high reset; clears q to 0
//   en_b     - active-low count enable
//   load_b   - active-low synchronous parallel load of load_in
//   up       - count direction: 1 = increment, 0 = decrement
//   load_in  - parallel load value
//   q        - registered count value
//   rco_b    - active-low terminal-count output (combinational)
//
// Configuration:
//   UP_DOWN_COUNTER_SAT_EN - when defined, counting saturates at the terminal
//                            count instead of wrapping. Load and reset are
//                            the same in both builds.
// ---------------------------------------------------------------------------
module up_down_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_b,
    input  logic         load_b,
    input  logic         up,
    input  logic [N-1:0] load_in,
    output logic [N-1:0] q,
    output logic         rco_b
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         at_terminal;

    // The terminal count depends on the direction: all ones when counting
    // up, zero when counting down. It drives both rco_b and saturation.
    always_comb begin
        at_terminal = 1'b0;
        if (up) begin
            at_terminal = (q_q == {N{1'b1}});
        end else begin
            at_terminal = (q_q == {N{1'b0}});
        end
    end

    // Next-state logic. Load beats count, and count beats hold. Reset is
    // applied in the register itself so that it overrides everything here.
    always_comb begin
        q_d = q_q;
        if (!load_b) begin
            q_d = load_in;
        end else if (!en_b) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            // Saturating build: at the terminal count q stays put. rco_b
            // still asserts, so a cascade can see the limit was reached.
            if (at_terminal) begin
                q_d = q_q;
            end else if (up) begin
                q_d = q_q + ONE;
            end else begin
                q_d = q_q - ONE;
            end
`else
            // Wrapping build: modulo-2^N arithmetic gives the wrap for free.
            if (up) begin
                q_d = q_q + ONE;
            end else begin
                q_d = q_q - ONE;
            end
`endif
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= {N{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

    // rco_b is deliberately unregistered. It follows en_b, up and q within
    // the same cycle, which lets a following stage enable on this one.
    assign rco_b = ~(~en_b & at_terminal);

endmodule

// File: tb/tb_up_down_counter.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter
//
// Drives a 4-bit and a 5-bit up_down_counter with shared control inputs.
// Directed vectors push hand-computed expected values into a scoreboard
// queue. A separate monitor process drains the queue and compares whenever
// a sample point is announced.
// ---------------------------------------------------------------------------
module tb_up_down_counter;

    typedef struct {
        int unsigned dut;
        logic [4:0]  q;
        logic        rco;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_b;
    logic       load_b;
    logic       up;
    logic [3:0] load_in4;
    logic [4:0] load_in5;
    logic [3:0] q4;
    logic [4:0] q5;
    logic       rco_b4;
    logic       rco_b5;

    exp_t scoreboard[$];
    event sample_ev;
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   stim_done = 1'b0;

    up_down_counter #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .en_b(en_b), .load_b(load_b), .up(up),
        .load_in(load_in4), .q(q4), .rco_b(rco_b4)
    );

    up_down_counter #(.N(5)) dut5 (
        .clk(clk), .reset(reset), .en_b(en_b), .load_b(load_b), .up(up),
        .load_in(load_in5), .q(q5), .rco_b(rco_b5)
    );

    always #5 clk = ~clk;

    // Expected rco_b from the current inputs and an expected count value.
    function automatic logic expRco(input int unsigned qv, input int width);
        logic term;
        term = up ? (qv == (2 ** width) - 1) : (qv == 0);
        return !(!en_b && term);
    endfunction

    // Drive inputs away from the active edge, then step one rising edge and
    // settle so the outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                 input logic u, input logic [3:0] l4,
                                 input logic [4:0] l5);
        @(negedge clk);
        reset = rst; en_b = en; load_b = ld; up = u;
        load_in4 = l4; load_in5 = l5;
        @(posedge clk);
        #1;
    endtask

    // Change inputs without a clock edge, for checking rco_b combinationally.
    task automatic applyNoEdge(input logic en, input logic u);
        @(negedge clk);
        en_b = en; up = u;
        #1;
    endtask

    task automatic expect4(input string tag, input int unsigned qv);
        exp_t e;
        e.dut = 4; e.q = 5'(qv); e.rco = expRco(qv, 4); e.tag = tag;
        scoreboard.push_back(e);
    endtask

    task automatic expect5(input string tag, input int unsigned qv);
        exp_t e;
        e.dut = 5; e.q = 5'(qv); e.rco = expRco(qv, 5); e.tag = tag;
        scoreboard.push_back(e);
    endtask

    // Compare one scoreboard entry against the selected DUT's outputs.
    task automatic checkOutput(input exp_t e);
        logic [4:0] act_q;
        logic       act_rco;
        act_q   = (e.dut == 4) ? {1'b0, q4} : q5;
        act_rco = (e.dut == 4) ? rco_b4 : rco_b5;
        tests_run++;
        if (act_q !== e.q || act_rco !== e.rco) begin
            tests_failed++;
            $display("[TB] FAIL %s (N=%0d): got q=%0d rco_b=%b, expected q=%0d rco_b=%b",
                     e.tag, e.dut, act_q, act_rco, e.q, e.rco);
        end
    endtask

    // Monitor: whenever a sample point is announced, drain the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput(e);
            end
        end
    end

    // Stimulus.
    initial begin
        reset = 1'b0; en_b = 1'b1; load_b = 1'b1; up = 1'b1;
        load_in4 = '0; load_in5 = '0;

        // Reset, then hold, then load 0 on both counters.
        applyStimulus(1, 1, 1, 1, 4'd0, 5'd0);
        expect4("reset", 0); expect5("reset", 0); -> sample_ev;
        applyStimulus(0, 1, 1, 1, 4'd0, 5'd0);
        expect4("hold_after_reset", 0); expect5("hold_after_reset", 0); -> sample_ev;
        applyStimulus(0, 1, 0, 1, 4'd0, 5'd0);
        expect4("load_zero", 0); expect5("load_zero", 0); -> sample_ev;

        // Count up for 32 edges: 4-bit wraps twice, 5-bit once.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
            expect4("count_up", (i + 1) % 16);
            expect5("count_up", (i + 1) % 32);
            -> sample_ev;
        end

        // Load 15 with counting disabled, then count down to 0.
        applyStimulus(0, 1, 0, 0, 4'd15, 5'd0);
        expect4("load_15", 15); -> sample_ev;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
            expect4("count_down", 14 - i); -> sample_ev;
        end
        // At q==0 counting down: disabling the count releases rco_b at once.
        applyNoEdge(1, 0);
        expect4("disable_rco", 0); -> sample_ev;
        applyStimulus(0, 1, 1, 0, 4'd0, 5'd0);
        expect4("hold_zero", 0); -> sample_ev;
        applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
        expect4("wrap_down", 15); -> sample_ev;

        // Load overrides counting, then counting resumes from the load.
        applyStimulus(0, 0, 0, 0, 4'b1010, 5'd0);
        expect4("load_1010", 10); -> sample_ev;
        applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
        expect4("after_load_down", 9); -> sample_ev;
        applyStimulus(0, 0, 0, 1, 4'b0101, 5'd0);
        expect4("load_0101", 5); -> sample_ev;
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("after_load_up", 6); -> sample_ev;

        // Reset overrides a pending load while counting.
        applyStimulus(0, 0, 0, 1, 4'd7, 5'd0);
        expect4("load_7", 7); -> sample_ev;
        applyStimulus(1, 0, 0, 1, 4'd3, 5'd0);
        expect4("reset_over_load", 0); -> sample_ev;
        // After reset with en_b low, rco_b follows the direction.
        applyNoEdge(0, 0);
        expect4("reset_rco_down", 0); -> sample_ev;
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("resume_after_reset", 1); -> sample_ev;

        // Terminal-count behaviour: wrap by default, saturate when enabled.
        applyStimulus(0, 1, 0, 1, 4'd14, 5'd0);
        expect4("load_14", 14); -> sample_ev;
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("term_up_1", 15); -> sample_ev;
`ifdef UP_DOWN_COUNTER_SAT_EN
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("sat_up_2", 15); -> sample_ev;
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("sat_up_3", 15); -> sample_ev;
`else
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("wrap_up_2", 0); -> sample_ev;
        applyStimulus(0, 0, 1, 1, 4'd0, 5'd0);
        expect4("wrap_up_3", 1); -> sample_ev;
`endif
        applyStimulus(0, 1, 0, 0, 4'd1, 5'd0);
        expect4("load_1", 1); -> sample_ev;
        applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
        expect4("term_down_1", 0); -> sample_ev;
`ifdef UP_DOWN_COUNTER_SAT_EN
        applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
        expect4("sat_down_2", 0); -> sample_ev;
`else
        applyStimulus(0, 0, 1, 0, 4'd0, 5'd0);
        expect4("wrap_down_2", 15); -> sample_ev;
`endif

        #2;
        if (scoreboard.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0",
                     scoreboard.size());
        end
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound the run in case stimulus stalls.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("[TB] FAIL timeout: stimulus not complete, expected completion");
            $fatal(1, "[TB] timeout");
        end
    end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 SHALL provide parameter N, default 4, giving the counter width in bits; legal range 2..32.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port en_b, input, 1 bit: active-low count enable.
REQ-005 SHALL provide port load_b, input, 1 bit: active-low synchronous parallel load.
REQ-006 SHALL provide port up, input, 1 bit: count direction; 1 = increment, 0 = decrement.
REQ-007 SHALL provide port load_in, input, N bits: parallel load value.
REQ-008 SHALL provide port q, output, N bits: registered count value.
REQ-009 SHALL provide port rco_b, output, 1 bit: active-low ripple-carry/terminal-count output.

Function
REQ-010 SHALL apply this priority on each rising clk edge: reset, then load_b==0, then en_b==0 count, else hold.
REQ-011 With load_b==0 and reset==0, q SHALL take load_in on the next edge, regardless of en_b and up.
REQ-012 With load_b==1 and en_b==0, q SHALL become q+1 mod 2^N when up==1, and q-1 mod 2^N when up==0.
REQ-013 With load_b==1 and en_b==1, q SHALL hold its value.
REQ-014 Wrap-around (default build): up from 2^N-1 SHALL give 0; down from 0 SHALL give 2^N-1.
REQ-015 Terminal count SHALL be defined as q==2^N-1 when up==1 and q==0 when up==0.
REQ-016 rco_b SHALL be combinational: 0 iff en_b==0 and q is at terminal count; otherwise 1.
REQ-017 rco_b SHALL respond within the same cycle to changes on up, en_b and q, with no register stage.
REQ-018 Changing up while en_b==0 SHALL take effect on the next edge; there is no pipeline latency.
REQ-019 Inputs SHALL be sampled only at rising clk edges; no asynchronous path SHALL exist to q.

Reset
REQ-020 reset==1 at a rising edge SHALL set q to 0, overriding load_b and en_b.
REQ-021 After reset, rco_b SHALL be 0 if en_b==0 and up==0; otherwise it SHALL be 1.
REQ-022 Asserting reset mid-count SHALL clear q on that edge; counting SHALL resume from 0 on the first edge after reset deasserts.
REQ-023 q SHALL be undefined between power-up and the first reset or load edge.

Configuration
REQ-024 Macro UP_DOWN_COUNTER_SAT_EN SHALL select saturating behaviour.
REQ-025 When UP_DOWN_COUNTER_SAT_EN is defined, counting up at 2^N-1 or down at 0 SHALL hold q, while rco_b still asserts per REQ-016.
REQ-026 When UP_DOWN_COUNTER_SAT_EN is undefined, the wrap behaviour of REQ-014 SHALL apply.
REQ-027 Load and reset behaviour SHALL be identical in both builds.

Verification
REQ-028 Verification SHALL cover these directed scenarios:
- N=4: reset, en_b=1, then load_b=0 with load_in=0, then en_b=0, load_b=1, up=1 for 16 edges -> q steps 0..15 then 0; rco_b=0 only while q==15.
- N=5, same stimulus for 32 edges -> q steps 0..31 then 0; rco_b=0 only while q==31.
- N=4: load_in=1111 with en_b=1, then up=0, en_b=0 -> q steps 15..0 then 15; rco_b=0 only at q==0; en_b=1 makes rco_b=1 and q holds.
- N=4 counting down: load_b=0 with load_in=1010 for one edge -> q=1010, then counting resumes at 1001; switch to up=1 and load 0101 -> q=0101, then 0110.
- Reset asserted while q=7 with en_b=0 and load_b=0 -> q=0 on that edge, load ignored.
- UP_DOWN_COUNTER_SAT_EN defined, N=4, up=1 from 14 -> q 14, 15, 15, 15; down from 1 -> q 1, 0, 0.
